// File: rtl/charattr_pkg.sv
// Shared types and helpers for the ping-pong character/attribute row store.
// Parity helper is only referenced when CHARATTR_ROW_PINGPONG_PARITY_EN is defined.
package charattr_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 88;
  localparam int PARITY_MAX_W  = 1024;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/charattr_row_dpram.sv
// Inferred simple dual-port RAM: one write port, one registered read port.
module charattr_row_dpram #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 88,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/charattr_row_pingpong.sv
// Double-buffered character/attribute row store with swap handshake and auto-clear.
// Optional stored-parity checking is enabled by defining CHARATTR_ROW_PINGPONG_PARITY_EN.
//
// state | meaning
// INIT  | clear both banks after reset, busy
// FILL  | fill bank accepts writes
// FULL  | fill bank complete, waiting for rd_swap
// CLEAR | blanking the bank just released by the video side, busy
module charattr_row_pingpong
  import charattr_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter int               DEPTH       = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = {WIDTH{1'b0}},
  localparam int              ADDR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  wr_done,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  input  logic                  rd_swap,
  output logic                  swap_ack,
  output logic                  underrun,
`ifdef CHARATTR_ROW_PINGPONG_PARITY_EN
  output logic                  parity_err,
`endif
  output logic                  busy
);

`ifdef CHARATTR_ROW_PINGPONG_PARITY_EN
  localparam int RAM_W = WIDTH + 1;
`else
  localparam int RAM_W = WIDTH;
`endif
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(DEPTH - 1);

  state_t                state, state_n;
  logic                  rd_bank, rd_bank_n;
  logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_n;
  logic                  started;
  logic                  swap_ack_n, underrun_n;

  logic                  wr_in_range, rd_in_range;
  logic [1:0]            bank_we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [WIDTH-1:0]      wdata;
  logic [RAM_W-1:0]      wword;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [RAM_W-1:0]      q0, q1, q_sel;

  logic                  s1_valid, s1_bank, s1_oob;

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_W;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_W;

  assign busy     = started && (state == INIT || state == CLEAR);
  assign wr_ready = (state == FILL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= INIT;
      rd_bank  <= 1'b0;
      clr_cnt  <= '0;
      started  <= 1'b0;
      swap_ack <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_n;
      rd_bank  <= rd_bank_n;
      clr_cnt  <= clr_cnt_n;
      started  <= 1'b1;
      swap_ack <= swap_ack_n;
      underrun <= underrun_n;
    end
  end

  always_comb begin
    state_n    = state;
    rd_bank_n  = rd_bank;
    clr_cnt_n  = clr_cnt;
    swap_ack_n = 1'b0;
    underrun_n = 1'b0;
    unique case (state)
      INIT, CLEAR: begin
        // INIT waits one clock after reset release so busy spans the full sweep
        if (started || state == CLEAR) begin
          if (clr_cnt == LAST_COL) begin
            state_n   = FILL;
            clr_cnt_n = '0;
          end else begin
            clr_cnt_n = clr_cnt + 1'b1;
          end
        end
      end
      FILL: begin
        if (wr_done) state_n = FULL;
      end
      FULL: begin
        if (rd_swap) begin
          rd_bank_n  = ~rd_bank;
          state_n    = CLEAR;
          clr_cnt_n  = '0;
          swap_ack_n = 1'b1;
        end
      end
      default: state_n = INIT;
    endcase
    if (rd_swap && state != FULL) underrun_n = 1'b1;
  end

  always_comb begin
    bank_we = 2'b00;
    waddr   = clr_cnt;
    wdata   = CLEAR_VALUE;
    unique case (state)
      INIT:  if (started) bank_we = 2'b11;
      CLEAR: bank_we[~rd_bank] = 1'b1;
      FILL: begin
        if (wr_en && wr_in_range) begin
          bank_we[~rd_bank] = 1'b1;
          waddr             = wr_addr;
          wdata             = wr_data;
        end
      end
      default: bank_we = 2'b00;
    endcase
  end

`ifdef CHARATTR_ROW_PINGPONG_PARITY_EN
  assign wword = {even_parity(PARITY_MAX_W'(wdata)), wdata};
`else
  assign wword = wdata;
`endif

  // Out-of-range reads still clock the RAM; the result is replaced by CLEAR_VALUE.
  assign raddr = rd_in_range ? rd_addr : '0;

  charattr_row_dpram #(.WIDTH(RAM_W), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bank0 (
    .clk     (clk),
    .wr_en   (bank_we[0]),
    .wr_addr (waddr),
    .wr_data (wword),
    .rd_en   (rd_en),
    .rd_addr (raddr),
    .rd_data (q0)
  );

  charattr_row_dpram #(.WIDTH(RAM_W), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bank1 (
    .clk     (clk),
    .wr_en   (bank_we[1]),
    .wr_addr (waddr),
    .wr_data (wword),
    .rd_en   (rd_en),
    .rd_addr (raddr),
    .rd_data (q1)
  );

  assign q_sel = s1_bank ? q1 : q0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid   <= 1'b0;
      s1_bank    <= 1'b0;
      s1_oob     <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
`ifdef CHARATTR_ROW_PINGPONG_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      s1_valid <= rd_en;
      if (rd_en) begin
        s1_bank <= rd_bank;
        s1_oob  <= !rd_in_range;
      end
      rd_valid <= s1_valid;
      if (s1_valid) rd_data <= s1_oob ? CLEAR_VALUE : q_sel[WIDTH-1:0];
`ifdef CHARATTR_ROW_PINGPONG_PARITY_EN
      parity_err <= s1_valid && !s1_oob && (^q_sel);
`endif
    end
  end

endmodule

// File: tb/tb_charattr_row_pingpong.sv
// Scoreboard bench for charattr_row_pingpong against a row-level reference model.
`timescale 1ns/1ps
module tb_charattr_row_pingpong;

  localparam int WIDTH = 32;
  localparam int DEPTH = 88;
  localparam int AW    = $clog2(DEPTH);
  localparam int PH_FILL = 0, PH_FULL = 1, PH_BUSY = 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             wr_en = 1'b0, wr_done = 1'b0, rd_en = 1'b0, rd_swap = 1'b0;
  logic [AW-1:0]    wr_addr = '0, rd_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             wr_ready, rd_valid, swap_ack, underrun, busy;
  logic [WIDTH-1:0] rd_data;
`ifdef CHARATTR_ROW_PINGPONG_PARITY_EN
  logic             parity_err;
`endif

  int checks = 0, errors = 0, cyc = 0, busy_cnt = 0;

  // Reference model: the row the video side sees and the row being filled.
  logic [WIDTH-1:0] rows [2][DEPTH];
  int mbank = 0;
  int mphase = PH_BUSY;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               due;
  } exp_t;
  exp_t exp_q[$];

  charattr_row_pingpong u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_done    (wr_done),
    .wr_ready   (wr_ready),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_swap    (rd_swap),
    .swap_ack   (swap_ack),
    .underrun   (underrun),
`ifdef CHARATTR_ROW_PINGPONG_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got %0d checks, required completion", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_read(input int a);
    if (a >= DEPTH) return '0;
    return rows[mbank][a];
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < DEPTH; i++) rows[b][i] = '0;
    mbank  = 0;
    mphase = PH_BUSY;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus; the model is updated in the order the rules apply.
  task automatic step(input bit we, input int wa, input logic [WIDTH-1:0] wd,
                      input bit re, input int ra, input bit done, input bit swp);
    bit e_ack, e_und;
    if (busy) busy_cnt++;
    wr_en   = we;
    wr_addr = AW'(wa);
    wr_data = wd;
    rd_en   = re;
    rd_addr = AW'(ra);
    wr_done = done;
    rd_swap = swp;
    if (re) exp_q.push_back('{model_read(ra), cyc + 2});
    if (we && mphase == PH_FILL && wa < DEPTH) rows[1-mbank][wa] = wd;
    e_ack = 1'b0;
    e_und = 1'b0;
    if (swp) begin
      if (mphase == PH_FULL) begin
        mbank = 1 - mbank;
        for (int i = 0; i < DEPTH; i++) rows[1-mbank][i] = '0;
        mphase = PH_BUSY;
        e_ack  = 1'b1;
      end else begin
        e_und = 1'b1;
      end
    end
    if (done && mphase == PH_FILL) mphase = PH_FULL;
    tick();
    chk("swap_ack", 32'(swap_ack), 32'(e_ack));
    chk("underrun", 32'(underrun), 32'(e_und));
    wr_en = 1'b0; wr_done = 1'b0; rd_en = 1'b0; rd_swap = 1'b0;
  endtask

  task automatic step_idle();
    step(1'b0, 0, '0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic wait_ready(input string name, input int exp_busy);
    int n;
    n = 0;
    while (!wr_ready && n < 400) begin
      step_idle();
      n++;
    end
    chk({name, "_wr_ready"}, 32'(wr_ready), 32'd1);
    chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    mphase = PH_FILL;
  endtask

  // Monitor: pops the scoreboard whenever a read result is due or presented.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        checks++; errors++;
        $display("FAIL rd_missing: no rd_valid, required data %h at cycle %0d", e.data, e.due);
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        chk("rd_valid", 32'(rd_valid), 32'd1);
        chk("rd_data", rd_data, e.data);
`ifdef CHARATTR_ROW_PINGPONG_PARITY_EN
        chk("parity_err", 32'(parity_err), 32'd0);
`endif
      end else if (rd_valid) begin
        checks++; errors++;
        $display("FAIL rd_spurious: rd_valid 1 with data %h, required 0", rd_data);
      end
    end
  end

  initial begin
    bit we, re, swp;
    int wa, ra;
    model_reset();
    #2 reset_n = 1'b0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_swap_ack", 32'(swap_ack), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    reset_n  = 1'b1;
    busy_cnt = 0;
    wait_ready("init", DEPTH);

    for (int i = 0; i < 6; i++) step(1'b0, 0, '0, 1'b1, $urandom_range(0, DEPTH-1), 1'b0, 1'b0);

    for (int c = 0; c < DEPTH; c++) step(1'b1, c, 32'h1000_0000 + 32'(c), 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 100, 32'hDEAD_BEEF, 1'b1, 100, 1'b0, 1'b0);
    step(1'b0, 0, '0, 1'b0, 0, 1'b1, 1'b0);
    chk("full_wr_ready", 32'(wr_ready), 32'd0);
    step(1'b1, 12, 32'h0BAD_0BAD, 1'b1, 5, 1'b0, 1'b0);
    step(1'b0, 0, '0, 1'b1, 3, 1'b0, 1'b1);
    busy_cnt = 0;
    step(1'b0, 0, '0, 1'b1, 3, 1'b0, 1'b0);
    step(1'b0, 0, '0, 1'b1, 5, 1'b0, 1'b0);
    step(1'b0, 0, '0, 1'b1, 12, 1'b0, 1'b0);
    step(1'b0, 0, '0, 1'b1, 100, 1'b0, 1'b0);
    wait_ready("swap1", DEPTH);

    step(1'b0, 0, '0, 1'b0, 0, 1'b0, 1'b1);
    chk("underrun_wr_ready", 32'(wr_ready), 32'd1);
    step(1'b1, 7, 32'hA5A5_0007, 1'b1, 5, 1'b0, 1'b0);
    step(1'b0, 0, '0, 1'b0, 0, 1'b1, 1'b1);
    chk("done_swap_full", 32'(wr_ready), 32'd0);
    step(1'b0, 0, '0, 1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, '0, 1'b1, 7, 1'b0, 1'b0);
    step(1'b0, 0, '0, 1'b1, 5, 1'b0, 1'b0);
    repeat (38) step_idle();
    chk("midclear_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midclear_rst_busy", 32'(busy), 32'd0);
    chk("midclear_rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("midclear_rst_rd_data", rd_data, 32'd0);
    chk("midclear_rst_rd_valid", 32'(rd_valid), 32'd0);
    exp_q.delete();
    model_reset();
    tick(); tick();
    reset_n  = 1'b1;
    busy_cnt = 0;
    wait_ready("reinit", DEPTH);
    for (int c = 0; c < DEPTH; c++) step(1'b0, 0, '0, 1'b1, c, 1'b0, 1'b0);
    step(1'b0, 0, '0, 1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, '0, 1'b0, 0, 1'b0, 1'b1);
    busy_cnt = 0;
    for (int c = 0; c < DEPTH; c++) step(1'b0, 0, '0, 1'b1, c, 1'b0, 1'b0);
    wait_ready("reinit_swap", DEPTH);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 60; i++) begin
        we  = 1'($urandom_range(0, 1));
        re  = 1'($urandom_range(0, 1));
        swp = ($urandom_range(0, 15) == 0);
        wa  = $urandom_range(0, DEPTH + 20);
        ra  = $urandom_range(0, DEPTH + 20);
        step(we, wa, $urandom, re, ra, 1'b0, swp);
      end
      step(1'b1, $urandom_range(0, DEPTH-1), $urandom, 1'b1, $urandom_range(0, DEPTH-1), 1'b1, 1'b0);
      step(1'b1, $urandom_range(0, DEPTH-1), $urandom, 1'b1, $urandom_range(0, DEPTH-1), 1'b0, 1'b0);
      chk("rand_full_wr_ready", 32'(wr_ready), 32'd0);
      step(1'b0, 0, '0, 1'b1, $urandom_range(0, DEPTH-1), 1'b0, 1'b1);
      busy_cnt = 0;
      for (int i = 0; i < 20; i++) step(1'b0, 0, '0, 1'b1, $urandom_range(0, DEPTH + 20), 1'b0, 1'b0);
      wait_ready("rand_swap", DEPTH);
    end

    repeat (4) step_idle();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/charattr_row_pingpong.md
Name: charattr_row_pingpong

Overview:
- Parametrised double-buffered (ping-pong) row store for character/attribute words; successor to the fixed 88x32 single-bank row RAM.
- Text fetch side fills one bank while the video side reads the other.
- A swap handshake exchanges banks at row boundaries.
- The newly freed bank is auto-cleared to a blank value before refill.
- Sits between the text-memory fetcher and the character generator pipeline, single clock domain.

Parameters:
- WIDTH, 32, bits per character/attribute word.
- DEPTH, 88, words per row (columns); any value 2..512.
- ADDR_WIDTH, $clog2(DEPTH), column address width; derived, not overridden.
- CLEAR_VALUE, {WIDTH{1'b0}}, blank word written during clear.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe, fill side.
- wr_addr  in  ADDR_WIDTH  column to write.
- wr_data  in  WIDTH  word to write.
- wr_done  in  1  pulse: fill bank complete.
- wr_ready  out  1  fill bank accepts writes.
- rd_en  in  1  read strobe, video side.
- rd_addr  in  ADDR_WIDTH  column to read.
- rd_data  out  WIDTH  read word, registered.
- rd_valid  out  1  rd_data valid.
- rd_swap  in  1  pulse: video side finished its row.
- swap_ack  out  1  one-cycle pulse: banks exchanged.
- underrun  out  1  one-cycle pulse: rd_swap with no full bank.
- busy  out  1  clear in progress.

Behaviour:
- Reset (async assert, sync release): rd_bank=0, state=INIT, clear counter=0, all outputs 0 (rd_data=0, wr_ready=0, busy=1 from first clock after release).
- Storage: 2*DEPTH x WIDTH simple dual-port RAM, one write port, one read port; read bank = rd_bank, fill bank = ~rd_bank.
- States:
  - INIT: writes CLEAR_VALUE to both banks, one word per bank per cycle in parallel, for DEPTH cycles, then FILL. busy=1, wr_ready=0.
  - FILL: wr_ready=1; wr_en with wr_addr<DEPTH writes the fill bank; wr_addr>=DEPTH is ignored. wr_done moves to FULL; a write on that same cycle is still performed.
  - FULL: wr_ready=0, writes ignored; waits for rd_swap.
  - CLEAR: busy=1, wr_ready=0; writes CLEAR_VALUE to the fill bank at counter 0..DEPTH-1 (one per cycle), then FILL.
- Swap:
  - rd_swap in FULL: rd_bank toggles on that edge, swap_ack=1 the next cycle, state goes to CLEAR.
  - rd_swap in FILL, CLEAR or INIT: no toggle, underrun=1 the next cycle, state unchanged; the video side repeats the old row.
- Read: rd_en at cycle N gives rd_data/rd_valid at N+2 (RAM read register plus output register).
  - Address is bound to rd_bank as sampled at cycle N; rd_swap and rd_en on the same cycle read the pre-swap bank.
  - rd_addr>=DEPTH returns CLEAR_VALUE.
  - rd_data holds its last value when rd_valid=0.
- Simultaneous wr_done and rd_swap while in FILL: counts as underrun; wr_done is still taken and the state becomes FULL.
- Counter wraps only via the state exit; no modular address arithmetic.
- reset_n low in any state aborts the operation and returns to INIT; RAM contents are rewritten by INIT.

Optional Feature:
- Macro: CHARATTR_ROW_PINGPONG_PARITY_EN.
- Defined:
  - RAM is WIDTH+1 wide; even parity of wr_data is stored per word (CLEAR_VALUE parity included).
  - Parity is checked on read.
  - Extra output parity_err (1 bit), pulses high aligned with rd_valid when the stored parity mismatches; reset value 0.
- Undefined: RAM is WIDTH wide, no parity_err port, no parity logic.

Decomposition:
- Shared package charattr_pkg holds:
  - state enum (INIT, FILL, FULL, CLEAR);
  - default WIDTH/DEPTH constants;
  - a parity function.
- One sub-module, charattr_row_dpram: inferred simple dual-port RAM, parametrised width and depth, registered read.
- Control FSM, bank select and clear counter live in the top module.

Test Plan:
- Reset release -> busy=1 for exactly 88 cycles, then wr_ready=1. Reading any column of bank 0 then returns 0 with rd_valid 2 cycles after rd_en.
- Fill columns 0..87 with value 0x1000_0000+col, pulse wr_done, pulse rd_swap:
  - swap_ack=1 next cycle;
  - rd_addr 5 returns 0x1000_0005;
  - busy=1 for 88 cycles, then wr_ready=1.
- rd_swap while in FILL -> underrun=1 one cycle, no swap_ack, reads still return the old row's data.
- rd_en to col 3 on the same cycle as a valid rd_swap -> returns old-bank col 3; rd_en one cycle later returns new-bank col 3.
- wr_addr=100 and rd_addr=100 with DEPTH=88 -> write ignored (neighbouring column 12 unchanged), read returns CLEAR_VALUE.
- Assert reset_n low mid-CLEAR (counter 40) -> outputs zero immediately. After release: INIT for 88 cycles, all columns of both banks read 0. With the parity macro, a corrupted stored bit forces parity_err=1 aligned with rd_valid.
